rr_mux_reg: RTL and testbench
=============================

Name: rr_mux_reg

Overview:
- Parametrised successor to the bit-sliced 2:1 word multiplexer.
- Selects one of NUM_IN channels, each WIDTH bits wide, and drives one registered output.
- Input and output use valid/ready handshakes.
- Two selection modes:
  - fixed: an external select picks the channel;
  - round-robin: fair arbitration over all valid channels.
- Used wherever several datapath sources share one downstream bus, for example register-file write-back or ALU operand sourcing.

Parameters:
- WIDTH, 8, data width of each channel in bits.
- NUM_IN, 4, number of input channels (2..16).
- SEL_W, 2, select/channel-index width; must equal ceil(log2(NUM_IN)).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous reset, active-high.
- in_data  input  NUM_IN*WIDTH  packed channel data; channel i occupies bits [i*WIDTH +: WIDTH].
- in_valid  input  NUM_IN  per-channel valid.
- in_ready  output  NUM_IN  per-channel ready; combinational.
- mode  input  1  0 = fixed select, 1 = round-robin.
- select  input  SEL_W  channel index used in fixed mode.
- out_data  output  WIDTH  registered output data.
- out_valid  output  1  output register holds a beat.
- out_ready  input  1  downstream accepts the beat.
- out_chan  output  SEL_W  registered index of the source channel.

Behaviour:
- Reset (synchronous, any cycle, including mid-transfer):
  - out_valid=0, out_data=0, out_chan=0, rr_ptr=NUM_IN-1;
  - any held beat is discarded;
  - in_ready=0 during the reset cycle.
- Output register:
  - load_en = !out_valid || out_ready.
  - Latency is 1 cycle from input transfer to out_valid.
  - Throughput is 1 beat/cycle; drain and load in the same cycle are allowed.
- Grant generation (combinational, one-hot or zero):
  - Fixed mode: grant[select]=in_valid[select]. If select >= NUM_IN, no grant.
  - Round-robin mode: search in_valid starting at rr_ptr+1, wrapping modulo NUM_IN. The first valid channel found wins.
- Handshake:
  - in_ready[i] = grant[i] && load_en && !reset.
  - A transfer occurs when in_valid[i] && in_ready[i]. On transfer: out_data<=channel i data, out_chan<=i, out_valid<=1.
  - Otherwise, if out_ready is high, out_valid<=0.
- Pointer update: rr_ptr<=i only on a transfer in round-robin mode. The pointer is unchanged in fixed mode and on idle cycles.
- Stall: while out_valid && !out_ready, out_data and out_chan are held stable and all in_ready are 0.
- Mode or select changes:
  - take effect in the cycle they change;
  - never alter a beat already held in the output register.
- No valid inputs: no transfer. out_valid drops after a drain.
- A dropped in_valid without a transfer is legal and leaves no residual state.

Optional Feature:
- Macro: RR_MUX_LOCK_EN.
- Defined:
  - Adds input in_last [NUM_IN] and output out_last [1], registered alongside out_data. out_last resets to 0.
  - In round-robin mode, after a transfer with in_last[i]=0, the grant locks to channel i; other channels are not granted.
  - The lock releases after a transfer with in_last[i]=1.
  - Reset clears the lock.
  - A change to fixed mode clears the lock.
- Undefined: no in_last or out_last ports; arbitration is per beat.

Test Plan (WIDTH=8, NUM_IN=4):
- Fixed mode, select=2, in_valid=4'b1111, ch2=8'hA5, out_ready=1:
  - in_ready=4'b0100;
  - next cycle out_data=8'hA5, out_chan=2, out_valid=1.
- Round-robin after reset, all valid, out_ready=1 for 6 cycles:
  - out_chan sequence 0,1,2,3,0,1;
  - one beat per cycle.
- Backpressure: beat from ch1=8'h3C held, out_ready=0 for 3 cycles:
  - out_data stays 8'h3C, out_valid=1, in_ready=0;
  - out_ready=1 → next beat loads in the same cycle.
- Round-robin sparse, in_valid=4'b1001, rr_ptr=0:
  - grants ch3, then ch0, then ch3;
  - ch1 and ch2 are never granted.
- Reset asserted while out_valid=1 with pending inputs:
  - next cycle out_valid=0, out_data=0, out_chan=0;
  - first grant after reset is ch0.
- RR_MUX_LOCK_EN defined:
  - ch2 sends 3 beats with in_last=0,0,1 while ch0 stays valid;
  - out_chan=2,2,2, then 0; out_last=1 on the third beat only.

Source files
------------

// File: rtl/rr_mux_reg.sv
// rr_mux_reg: NUM_IN-way valid/ready mux, fixed or round-robin select, registered output.
// Define RR_MUX_LOCK_EN to add in_last/out_last and lock round-robin grants per packet.
module rr_mux_reg #(
  parameter int WIDTH  = 8,
  parameter int NUM_IN = 4,
  parameter int SEL_W  = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [NUM_IN-1:0]       in_valid,
  output logic [NUM_IN-1:0]       in_ready,
`ifdef RR_MUX_LOCK_EN
  input  logic [NUM_IN-1:0]       in_last,
  output logic                    out_last,
`endif
  input  logic                    mode,
  input  logic [SEL_W-1:0]        select,
  output logic [WIDTH-1:0]        out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [SEL_W-1:0]        out_chan
);

  localparam logic [SEL_W:0]   NUM_L   = (SEL_W+1)'(NUM_IN);
  localparam logic [SEL_W-1:0] LAST_CH = SEL_W'(NUM_IN-1);

  logic [SEL_W-1:0] rr_ptr;
  logic [NUM_IN-1:0] grant;
  logic [SEL_W-1:0] gidx;
  logic [WIDTH-1:0] sel_data;
  logic load_en;
  logic xfer;

`ifdef RR_MUX_LOCK_EN
  logic             lock_q;
  logic [SEL_W-1:0] lock_ch;
  logic             sel_last;
`endif

  // One-hot grant: external select, held lock, or rotating search after rr_ptr
  always_comb begin : grant_gen
    logic             found;
    logic [SEL_W-1:0] idx;
    grant = '0;
    gidx  = '0;
    found = 1'b0;
    idx   = '0;
    if (!mode) begin
      if ({1'b0, select} < NUM_L) begin
        grant[select] = in_valid[select];
        gidx          = select;
      end
    end
`ifdef RR_MUX_LOCK_EN
    else if (lock_q) begin
      grant[lock_ch] = in_valid[lock_ch];
      gidx           = lock_ch;
    end
`endif
    else begin
      for (int k = 1; k <= NUM_IN; k++) begin
        idx = SEL_W'((int'(rr_ptr) + k) % NUM_IN);
        if (!found && in_valid[idx]) begin
          grant[idx] = 1'b1;
          gidx       = idx;
          found      = 1'b1;
        end
      end
    end
  end

  // Data of the granted channel
  always_comb begin
    sel_data = '0;
    for (int i = 0; i < NUM_IN; i++)
      if (grant[i]) sel_data = in_data[i*WIDTH +: WIDTH];
  end

`ifdef RR_MUX_LOCK_EN
  assign sel_last = |(in_last & grant);
`endif

  assign load_en  = !out_valid || out_ready;
  assign in_ready = grant & {NUM_IN{load_en && !reset}};
  assign xfer     = |in_ready;

  // Output register, round-robin pointer and packet lock
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_chan  <= '0;
      rr_ptr    <= LAST_CH;
`ifdef RR_MUX_LOCK_EN
      out_last  <= 1'b0;
      lock_q    <= 1'b0;
      lock_ch   <= '0;
`endif
    end else begin
      if (xfer) begin
        out_data  <= sel_data;
        out_chan  <= gidx;
        out_valid <= 1'b1;
`ifdef RR_MUX_LOCK_EN
        out_last  <= sel_last;
`endif
        if (mode) rr_ptr <= gidx;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
`ifdef RR_MUX_LOCK_EN
      if (!mode) begin
        lock_q <= 1'b0;
      end else if (xfer) begin
        lock_q  <= !sel_last;
        lock_ch <= gidx;
      end
`endif
    end
  end

endmodule

// File: tb/tb_rr_mux_reg.sv
// tb_rr_mux_reg: vector table plus scoreboard for rr_mux_reg (WIDTH=8, NUM_IN=4).
// Define RR_MUX_LOCK_EN to also exercise packet locking.
module tb_rr_mux_reg;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] in_data;
  logic [3:0]  in_valid;
  logic [3:0]  in_ready;
  logic [3:0]  in_last;
  logic        mode;
  logic [1:0]  select;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready;
  logic [1:0]  out_chan;
`ifdef RR_MUX_LOCK_EN
  logic        out_last;
`endif

  always #5 clk = ~clk;

  rr_mux_reg #(.WIDTH(8), .NUM_IN(4), .SEL_W(2)) dut (
    .clk(clk),
    .reset(reset),
    .in_data(in_data),
    .in_valid(in_valid),
    .in_ready(in_ready),
`ifdef RR_MUX_LOCK_EN
    .in_last(in_last),
    .out_last(out_last),
`endif
    .mode(mode),
    .select(select),
    .out_data(out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_chan(out_chan)
  );

  typedef struct {
    logic [7:0] d;
    logic [1:0] ch;
    logic       last;
  } beat_t;

  typedef struct {
    logic       m;
    logic [1:0] sel;
    logic [3:0] v;
    logic       ordy;
    logic [3:0] rdy;
  } vec_t;

  beat_t q[$];
  vec_t  tbl[16];
  int    total = 0;
  int    bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic mon(input string nm);
    chk({nm, " out_valid"}, 32'(out_valid), 32'(q.size() != 0));
    if (out_valid && q.size() != 0) begin
      chk({nm, " out_data"}, 32'(out_data), 32'(q[0].d));
      chk({nm, " out_chan"}, 32'(out_chan), 32'(q[0].ch));
`ifdef RR_MUX_LOCK_EN
      chk({nm, " out_last"}, 32'(out_last), 32'(q[0].last));
`endif
      if (out_ready) void'(q.pop_front());
    end
  endtask

  task automatic cyc(input logic m, input logic [1:0] s,
                     input logic [3:0] v, input logic r,
                     input logic [3:0] er, input string nm);
    mode      = m;
    select    = s;
    in_valid  = v;
    out_ready = r;
    @(negedge clk);
    mon(nm);
    chk({nm, " in_ready"}, 32'(in_ready), 32'(er));
    for (int i = 0; i < 4; i++)
      if (er[i]) q.push_back('{in_data[i*8 +: 8], 2'(i), in_last[i]});
    @(posedge clk);
    #1;
  endtask

  initial begin
    in_data   = {8'h5A, 8'hA5, 8'h3C, 8'hC3};
    reset     = 1'b1;
    mode      = 1'b1;
    select    = 2'd0;
    in_valid  = 4'hF;
    out_ready = 1'b1;
    in_last   = 4'hF;

    tbl[0]  = '{1'b0, 2'd2, 4'b1111, 1'b1, 4'b0100};
    tbl[1]  = '{1'b1, 2'd0, 4'b1111, 1'b1, 4'b0001};
    tbl[2]  = '{1'b1, 2'd0, 4'b1111, 1'b1, 4'b0010};
    tbl[3]  = '{1'b1, 2'd0, 4'b1111, 1'b1, 4'b0100};
    tbl[4]  = '{1'b1, 2'd0, 4'b1111, 1'b1, 4'b1000};
    tbl[5]  = '{1'b1, 2'd0, 4'b1111, 1'b1, 4'b0001};
    tbl[6]  = '{1'b1, 2'd0, 4'b1111, 1'b1, 4'b0010};
    tbl[7]  = '{1'b0, 2'd1, 4'b0010, 1'b0, 4'b0000};
    tbl[8]  = '{1'b0, 2'd1, 4'b0010, 1'b0, 4'b0000};
    tbl[9]  = '{1'b0, 2'd1, 4'b0010, 1'b0, 4'b0000};
    tbl[10] = '{1'b0, 2'd1, 4'b0010, 1'b1, 4'b0010};
    tbl[11] = '{1'b1, 2'd0, 4'b1001, 1'b1, 4'b1000};
    tbl[12] = '{1'b1, 2'd0, 4'b1001, 1'b1, 4'b0001};
    tbl[13] = '{1'b1, 2'd0, 4'b1001, 1'b1, 4'b1000};
    tbl[14] = '{1'b1, 2'd0, 4'b0000, 1'b1, 4'b0000};
    tbl[15] = '{1'b1, 2'd0, 4'b0000, 1'b1, 4'b0000};

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset in_ready", 32'(in_ready), 32'd0);
    chk("reset out_valid", 32'(out_valid), 32'd0);
    chk("reset out_data", 32'(out_data), 32'd0);
    chk("reset out_chan", 32'(out_chan), 32'd0);
`ifdef RR_MUX_LOCK_EN
    chk("reset out_last", 32'(out_last), 32'd0);
`endif
    @(posedge clk);
    #1;
    reset = 1'b0;

    for (int i = 0; i < 16; i++)
      cyc(tbl[i].m, tbl[i].sel, tbl[i].v, tbl[i].ordy, tbl[i].rdy,
          $sformatf("vec%0d", i));

    cyc(1'b1, 2'd0, 4'hF, 1'b0, 4'b0001, "pre_rst");
    reset     = 1'b1;
    out_ready = 1'b1;
    in_valid  = 4'hF;
    @(negedge clk);
    chk("mid_rst in_ready", 32'(in_ready), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    q.delete();
    chk("post_rst out_valid", 32'(out_valid), 32'd0);
    chk("post_rst out_data", 32'(out_data), 32'd0);
    chk("post_rst out_chan", 32'(out_chan), 32'd0);
    cyc(1'b1, 2'd0, 4'hF, 1'b1, 4'b0001, "rst_first");
    cyc(1'b1, 2'd0, 4'h0, 1'b1, 4'b0000, "rst_drain");

`ifdef RR_MUX_LOCK_EN
    in_last = 4'hF;
    cyc(1'b1, 2'd0, 4'b0010, 1'b1, 4'b0010, "lk_ptr");
    in_last = 4'b1011;
    cyc(1'b1, 2'd0, 4'b0101, 1'b1, 4'b0100, "lk_b0");
    cyc(1'b1, 2'd0, 4'b0101, 1'b1, 4'b0100, "lk_b1");
    in_last = 4'hF;
    cyc(1'b1, 2'd0, 4'b0101, 1'b1, 4'b0100, "lk_b2");
    in_last = 4'b1110;
    cyc(1'b1, 2'd0, 4'b0101, 1'b1, 4'b0001, "lk_rel");
    cyc(1'b0, 2'd2, 4'b0101, 1'b1, 4'b0100, "lk_fix");
    in_last = 4'hF;
    cyc(1'b1, 2'd0, 4'b0101, 1'b1, 4'b0100, "lk_clr");
    cyc(1'b1, 2'd0, 4'b0000, 1'b1, 4'b0000, "lk_drain");
`endif

    cyc(1'b1, 2'd0, 4'b0000, 1'b1, 4'b0000, "end_idle");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
